pipe_elastic_stage: RTL and testbench

Parametrised elastic pipeline stage buffer for the five-stage core. It generalises the single-entry valid/allow-in stage register used between IF, ID, EX, ME and WB into a DEPTH-entry FIFO carrying a BUS_W-wide stage bus. It adds a synchronous flush for branch and exception squash, an occupancy count, and a selectable allow-in mode. The first user is the IF→ID boundary, where it acts as an instruction prefetch queue; any other stage boundary may use it with DEPTH=1.

---
 rtl/pipe_elastic_stage_pkg.sv | 20 ++
 rtl/pipe_elastic_stage.sv | 83 ++++++++
 tb/tb_pipe_elastic_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_elastic_stage_pkg.sv
// Stage bus widths and default queue depths for each pipeline boundary of the five-stage core,
// plus sizing helpers shared by the elastic stage buffers.
package pipe_elastic_stage_pkg;

  localparam int IF_TO_ID_BUS_W = 64;
  localparam int ID_TO_EX_BUS_W = 150;
  localparam int EX_TO_ME_BUS_W = 71;
  localparam int ME_TO_WB_BUS_W = 70;

  // IF->ID doubles as the prefetch queue; the other boundaries stay single-entry.
  localparam int IF_TO_ID_DEPTH = 4;
  localparam int ID_TO_EX_DEPTH = 1;
  localparam int EX_TO_ME_DEPTH = 1;
  localparam int ME_TO_WB_DEPTH = 1;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// DEPTH-entry elastic stage buffer with synchronous flush; head appears one edge after push (no fall-through).
// Backpressure: allow_in drops when full, optionally re-opened combinationally by next_allow_in (PASS_ALLOW=1).
module pipe_elastic_stage
  import pipe_elastic_stage_pkg::*;
#(
  parameter int BUS_W      = IF_TO_ID_BUS_W,
  parameter int DEPTH      = 1,
  parameter int PASS_ALLOW = 1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             prev_valid,
  input  logic [BUS_W-1:0] prev_bus,
  output logic             allow_in,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_bus,
  input  logic             next_allow_in,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Non-power-of-two depths wrap explicitly rather than relying on overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_bus   = mem[rd_ptr];

  generate
    if (PASS_ALLOW != 0) begin : g_pass_allow
      assign allow_in = !full || next_allow_in;
    end else begin : g_reg_allow
      assign allow_in = !full;
    end
  endgenerate

  assign push = prev_valid && allow_in && !flush;
  assign pop  = out_valid && next_allow_in && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= prev_bus;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Drives four stage-buffer configurations from one stimulus stream and checks each against a
// list-based queue model, plus a classic single-entry stage-register model for the DEPTH=1 case.
module tb_pipe_elastic_stage;

  localparam int BW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          prev_valid;
  logic [BW-1:0] prev_bus;
  logic          next_allow_in;
  logic          flush;

  logic          ov  [N];
  logic [BW-1:0] ob  [N];
  logic          ai  [N];
  logic          fu  [N];
  logic [4:0]    cnt [N];
  logic [0:0]    c0;
  logic [1:0]    c1, c2, c3;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.BUS_W(BW), .DEPTH(1), .PASS_ALLOW(1)) u_d1_pass (
    .clk(clk), .resetn(resetn), .prev_valid(prev_valid), .prev_bus(prev_bus),
    .allow_in(ai[0]), .out_valid(ov[0]), .out_bus(ob[0]), .next_allow_in(next_allow_in),
    .flush(flush), .count(c0), .full(fu[0]));

  pipe_elastic_stage #(.BUS_W(BW), .DEPTH(3), .PASS_ALLOW(0)) u_d3_reg (
    .clk(clk), .resetn(resetn), .prev_valid(prev_valid), .prev_bus(prev_bus),
    .allow_in(ai[1]), .out_valid(ov[1]), .out_bus(ob[1]), .next_allow_in(next_allow_in),
    .flush(flush), .count(c1), .full(fu[1]));

  pipe_elastic_stage #(.BUS_W(BW), .DEPTH(2), .PASS_ALLOW(1)) u_d2_pass (
    .clk(clk), .resetn(resetn), .prev_valid(prev_valid), .prev_bus(prev_bus),
    .allow_in(ai[2]), .out_valid(ov[2]), .out_bus(ob[2]), .next_allow_in(next_allow_in),
    .flush(flush), .count(c2), .full(fu[2]));

  pipe_elastic_stage #(.BUS_W(BW), .DEPTH(2), .PASS_ALLOW(0)) u_d2_reg (
    .clk(clk), .resetn(resetn), .prev_valid(prev_valid), .prev_bus(prev_bus),
    .allow_in(ai[3]), .out_valid(ov[3]), .out_bus(ob[3]), .next_allow_in(next_allow_in),
    .flush(flush), .count(c3), .full(fu[3]));

  assign cnt[0] = 5'(c0);
  assign cnt[1] = 5'(c1);
  assign cnt[2] = 5'(c2);
  assign cnt[3] = 5'(c3);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: per-instance ordered list, element 0 is the head.
  int            mdep  [N] = '{1, 3, 2, 2};
  bit            mpass [N] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int            msz   [N];
  logic [BW-1:0] mq    [N][16];
  bit            sr_v;
  logic [BW-1:0] sr_d;

  function automatic bit m_allow(input int i);
    if (mpass[i]) return (msz[i] < mdep[i]) || next_allow_in;
    return msz[i] < mdep[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) msz[i] = 0;
    sr_v = 1'b0;
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("i%0d_allow_in", i), 64'(ai[i]), 64'(m_allow(i)));
      chk($sformatf("i%0d_out_valid", i), 64'(ov[i]), 64'(msz[i] != 0));
      chk($sformatf("i%0d_count", i), 64'(cnt[i]), 64'(msz[i]));
      chk($sformatf("i%0d_full", i), 64'(fu[i]), 64'(msz[i] == mdep[i]));
      if (msz[i] != 0) chk($sformatf("i%0d_out_bus", i), 64'(ob[i]), 64'(mq[i][0]));
    end
    chk("stage_reg_valid", 64'(ov[0]), 64'(sr_v));
    if (sr_v) chk("stage_reg_bus", 64'(ob[0]), 64'(sr_d));
  endtask

  task automatic advance();
    bit push, pop, sr_allow;
    for (int i = 0; i < N; i++) begin
      push = prev_valid && m_allow(i) && !flush;
      pop  = (msz[i] != 0) && next_allow_in && !flush;
      if (flush) begin
        msz[i] = 0;
      end else begin
        if (pop) begin
          for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
          msz[i]--;
        end
        if (push) begin
          mq[i][msz[i]] = prev_bus;
          msz[i]++;
        end
      end
    end
    sr_allow = !sr_v || next_allow_in;
    if (flush) begin
      sr_v = 1'b0;
    end else if (sr_allow) begin
      sr_v = prev_valid;
      if (prev_valid) sr_d = prev_bus;
    end
  endtask

  task automatic cycle(input bit pv, input logic [BW-1:0] bus, input bit nai, input bit fl);
    @(negedge clk);
    prev_valid    = pv;
    prev_bus      = bus;
    next_allow_in = nai;
    flush         = fl;
    #1;
    check_all();
    advance();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int thr;
    resetn        = 1'b0;
    prev_valid    = 1'b0;
    prev_bus      = '0;
    next_allow_in = 1'b0;
    flush         = 1'b0;
    m_reset();
    #3;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_i%0d_out_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_i%0d_out_bus", i), 64'(ob[i]), 64'd0);
      chk($sformatf("rst_i%0d_count", i), 64'(cnt[i]), 64'd0);
      chk($sformatf("rst_i%0d_allow_in", i), 64'(ai[i]), 64'd1);
      chk($sformatf("rst_i%0d_full", i), 64'(fu[i]), 64'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // First push after reset release.
    cycle(1'b1, 32'h1234, 1'b0, 1'b0);
    settle();
    chk("first_out_valid", 64'(ov[0]), 64'd1);
    chk("first_out_bus", 64'(ob[0]), 64'h1234);
    chk("first_count", 64'(cnt[0]), 64'd1);

    // Fill DEPTH=3, drain two, push two more so both pointers wrap past 2.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    settle();
    chk("fill_d3_full", 64'(fu[1]), 64'd1);
    chk("fill_d3_allow_in", 64'(ai[1]), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'hD, 1'b0, 1'b0);
    cycle(1'b1, 32'hE, 1'b0, 1'b0);
    settle();
    chk("wrap_d3_head", 64'(ob[1]), 64'hC);
    chk("wrap_d3_count", 64'(cnt[1]), 64'd3);
    cycle(1'b0, '0, 1'b1, 1'b0);
    settle();
    chk("wrap_d3_second", 64'(ob[1]), 64'hD);
    cycle(1'b0, '0, 1'b1, 1'b0);
    settle();
    chk("wrap_d3_third", 64'(ob[1]), 64'hE);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Full DEPTH=2 with simultaneous push and pop offered.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b1, 1'b0);
    settle();
    chk("pt_pass_count", 64'(cnt[2]), 64'd2);
    chk("pt_pass_head", 64'(ob[2]), 64'h22);
    chk("pt_reg_count", 64'(cnt[3]), 64'd1);
    chk("pt_reg_head", 64'(ob[3]), 64'h22);

    // Flush while a push and pop are both offered.
    cycle(1'b1, 32'h44, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b1, 1'b1);
    settle();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("flush_i%0d_count", i), 64'(cnt[i]), 64'd0);
      chk($sformatf("flush_i%0d_out_valid", i), 64'(ov[i]), 64'd0);
    end
    cycle(1'b1, 32'h66, 1'b0, 1'b0);
    settle();
    chk("post_flush_bus", 64'(ob[2]), 64'h66);
    chk("post_flush_count", 64'(cnt[2]), 64'd1);

    // Asynchronous reset between edges with two entries held.
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
    @(negedge clk);
    prev_valid = 1'b0;
    flush      = 1'b0;
    chk("pre_areset_count", 64'(cnt[2]), 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("areset_i%0d_out_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("areset_i%0d_out_bus", i), 64'(ob[i]), 64'd0);
      chk($sformatf("areset_i%0d_count", i), 64'(cnt[i]), 64'd0);
      chk($sformatf("areset_i%0d_allow_in", i), 64'(ai[i]), 64'd1);
    end
    m_reset();
    @(negedge clk);
    resetn = 1'b1;

    // Random traffic with varying downstream backpressure and occasional flush.
    for (int n = 0; n < 10000; n++) begin
      thr = (n / 1000) % 4;
      cycle($urandom_range(0, 3) != 0, BW'($urandom), $urandom_range(0, 3) <= thr,
            $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
